cache_lu_arb: RTL and testbench

CACHE_LU_ARB -- requirements
Module: cache_lu_arb

---
 rtl/cache_lu_arb.sv | 185 ++++++++++++++++++
 tb/tb_cache_lu_arb.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_lu_arb.sv
// ---------------------------------------------------------------------------
// cache_lu_arb
//
// Purpose:
//    Arbitrates between the core lookup port and the fill lookup port for
//    access to the cache lookup pipe. Fills normally win. A waiting core
//    request is guaranteed a slot after MAX_FILL_STREAK consecutive fill
//    grants. The winning request is registered onto lu_req one cycle after
//    acceptance. A stalled pipe freezes both the output register and the
//    streak counter.
//
// Parameters:
//    MAX_FILL_STREAK  maximum consecutive fill grants while a core request
//                     waits (legal range 1..7)
//
// Ports:
//    clk              rising-edge clock
//    rst              synchronous active-high reset
//    core_lu_valid    core lookup request present
//    core_lu_op       core opcode (RD_LU / WR_LU legal)
//    core_lu_tq_id    originating TQ entry of the core request
//    core_lu_address  core byte address
//    core_lu_data     core write word
//    core_lu_ready    core request accepted this cycle (combinational)
//    fill_lu_valid    fill lookup request present
//    fill_lu_tq_id    originating TQ entry of the fill
//    fill_lu_address  fill address
//    fill_lu_cl_data  fill cache line
//    fill_lu_ready    fill request accepted this cycle (combinational)
//    pipe_stall       lookup pipe cannot advance
//    lu_req           registered request {valid, lu_op, tq_id, address,
//                     cl_data, data}, 186 bits, valid is the MSB
//    arb_err          sticky flag, set by an illegal core opcode
// ---------------------------------------------------------------------------
module cache_lu_arb #(
   parameter int unsigned MAX_FILL_STREAK = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           core_lu_valid,
   input  logic [1:0]     core_lu_op,
   input  logic [2:0]     core_lu_tq_id,
   input  logic [19:0]    core_lu_address,
   input  logic [31:0]    core_lu_data,
   output logic           core_lu_ready,
   input  logic           fill_lu_valid,
   input  logic [2:0]     fill_lu_tq_id,
   input  logic [19:0]    fill_lu_address,
   input  logic [127:0]   fill_lu_cl_data,
   output logic           fill_lu_ready,
   input  logic           pipe_stall,
   output logic [185:0]   lu_req,
   output logic           arb_err
);

   // Lookup opcodes carried on the request bus.
   typedef enum logic [1:0] {
      NO_LU   = 2'd0,
      RD_LU   = 2'd1,
      WR_LU   = 2'd2,
      FILL_LU = 2'd3
   } t_lu_opcode;

   // Request bus layout. Field order fixes the bit positions on lu_req.
   typedef struct packed {
      logic         valid;
      t_lu_opcode   lu_op;
      logic [2:0]   tq_id;
      logic [19:0]  address;
      logic [127:0] cl_data;
      logic [31:0]  data;
   } t_lu_req;

   // Outcome of arbitration for the current cycle.
   typedef enum logic [1:0] {
      GRANT_NONE = 2'd0,
      GRANT_FILL = 2'd1,
      GRANT_CORE = 2'd2
   } t_grant;

   localparam logic [2:0] STREAK_MAX = 3'(MAX_FILL_STREAK);

   t_grant     grant;
   logic       core_wins;
   logic       core_op_legal;
   logic [2:0] streak_q;
   logic [2:0] streak_next;
   t_lu_req    lu_req_q;
   t_lu_req    lu_req_next;
   logic       arb_err_q;
   logic       arb_err_next;

   // Arbitration decision. A core request wins outright when there is no
   // fill, or when fills have already taken MAX_FILL_STREAK slots in a row
   // while it waited. Nothing is granted during reset or while the pipe is
   // stalled, so both readies drop to zero in those cycles. Keeping a
   // single grant value means that at most one ready can be high.
   always_comb begin
      grant         = GRANT_NONE;
      core_wins     = core_lu_valid && (!fill_lu_valid || (streak_q == STREAK_MAX));
      core_op_legal = (core_lu_op == RD_LU) || (core_lu_op == WR_LU);
      if (!rst && !pipe_stall) begin
         if (fill_lu_valid && !core_wins) begin
            grant = GRANT_FILL;
         end else if (core_lu_valid) begin
            grant = GRANT_CORE;
         end
      end
   end

   assign core_lu_ready = (grant == GRANT_CORE);
   assign fill_lu_ready = (grant == GRANT_FILL);

   // Next value of the fill streak. The streak only counts fills that
   // happen while a core request is actually waiting. It saturates at the
   // limit, and it resets once the core is served or stops asking. A
   // stalled cycle grants nothing, so the count is left untouched.
   always_comb begin
      streak_next = streak_q;
      if (!pipe_stall) begin
         if (!core_lu_valid) begin
            streak_next = 3'd0;
         end else if (grant == GRANT_CORE) begin
            streak_next = 3'd0;
         end else if ((grant == GRANT_FILL) && (streak_q != STREAK_MAX)) begin
            streak_next = streak_q + 3'd1;
         end
      end
   end

   // Build the request to be registered. A fill is always tagged FILL_LU
   // and carries no write word. A core request carries its own opcode and
   // no line data. A core request with an opcode that is not RD/WR is still
   // accepted, so the requester does not hang. It then produces an empty
   // bus cycle and raises the sticky error instead.
   always_comb begin
      lu_req_next  = '0;
      arb_err_next = arb_err_q;
      case (grant)
         GRANT_FILL: begin
            lu_req_next.valid   = 1'b1;
            lu_req_next.lu_op   = FILL_LU;
            lu_req_next.tq_id   = fill_lu_tq_id;
            lu_req_next.address = fill_lu_address;
            lu_req_next.cl_data = fill_lu_cl_data;
         end
         GRANT_CORE: begin
            if (core_op_legal) begin
               lu_req_next.valid   = 1'b1;
               lu_req_next.lu_op   = t_lu_opcode'(core_lu_op);
               lu_req_next.tq_id   = core_lu_tq_id;
               lu_req_next.address = core_lu_address;
               lu_req_next.data    = core_lu_data;
            end else begin
               arb_err_next = 1'b1;
            end
         end
         default: begin
            lu_req_next = '0;
         end
      endcase
   end

   // State registers. Reset wins over everything, including a stall. While
   // the pipe is stalled the output bus is frozen bit for bit, so the
   // downstream stage can keep sampling the same request. The streak and
   // error next-state logic already account for stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         lu_req_q  <= '0;
         streak_q  <= 3'd0;
         arb_err_q <= 1'b0;
      end else begin
         if (!pipe_stall) begin
            lu_req_q <= lu_req_next;
         end
         streak_q  <= streak_next;
         arb_err_q <= arb_err_next;
      end
   end

   assign lu_req  = lu_req_q;
   assign arb_err = arb_err_q;

endmodule

// File: tb/tb_cache_lu_arb.sv
// ---------------------------------------------------------------------------
// tb_cache_lu_arb
//
// Self-checking bench for cache_lu_arb with MAX_FILL_STREAK = 4.
// The stimulus process drives directed vectors and checks the readies.
// Each expected lu_req is pushed into a queue. A monitor process pops that
// queue and compares it with every freshly loaded lu_req.
// ---------------------------------------------------------------------------
module tb_cache_lu_arb;

   localparam int unsigned MAXF = 4;

   localparam logic [1:0] OP_NO   = 2'd0;
   localparam logic [1:0] OP_RD   = 2'd1;
   localparam logic [1:0] OP_WR   = 2'd2;
   localparam logic [1:0] OP_FILL = 2'd3;

   logic           clk;
   logic           rst;
   logic           core_lu_valid;
   logic [1:0]     core_lu_op;
   logic [2:0]     core_lu_tq_id;
   logic [19:0]    core_lu_address;
   logic [31:0]    core_lu_data;
   logic           core_lu_ready;
   logic           fill_lu_valid;
   logic [2:0]     fill_lu_tq_id;
   logic [19:0]    fill_lu_address;
   logic [127:0]   fill_lu_cl_data;
   logic           fill_lu_ready;
   logic           pipe_stall;
   logic [185:0]   lu_req;
   logic           arb_err;

   int             checks = 0;
   int             errors = 0;
   logic [185:0]   exp_q[$];
   logic           mon_loaded = 1'b0;

   cache_lu_arb #(.MAX_FILL_STREAK(MAXF)) dut (
      .clk             (clk),
      .rst             (rst),
      .core_lu_valid   (core_lu_valid),
      .core_lu_op      (core_lu_op),
      .core_lu_tq_id   (core_lu_tq_id),
      .core_lu_address (core_lu_address),
      .core_lu_data    (core_lu_data),
      .core_lu_ready   (core_lu_ready),
      .fill_lu_valid   (fill_lu_valid),
      .fill_lu_tq_id   (fill_lu_tq_id),
      .fill_lu_address (fill_lu_address),
      .fill_lu_cl_data (fill_lu_cl_data),
      .fill_lu_ready   (fill_lu_ready),
      .pipe_stall      (pipe_stall),
      .lu_req          (lu_req),
      .arb_err         (arb_err)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected bus image for a fill grant.
   function automatic logic [185:0] mk_fill(input logic [2:0] tq, input logic [19:0] addr,
                                            input logic [127:0] cl);
      return {1'b1, OP_FILL, tq, addr, cl, 32'd0};
   endfunction

   // Expected bus image for a legal core grant.
   function automatic logic [185:0] mk_core(input logic [1:0] op, input logic [2:0] tq,
                                            input logic [19:0] addr, input logic [31:0] d);
      return {1'b1, op, tq, addr, 128'd0, d};
   endfunction

   // Distinct cache line pattern for each fill index.
   function automatic logic [127:0] cl_of(input int k);
      logic [31:0] w;
      w = 32'hF00D0000 + 32'(k);
      return {w, ~w, w, ~w};
   endfunction

   // One comparison. It bumps the counters and reports on a mismatch.
   task automatic checkOutput(input string name, input logic [185:0] act, input logic [185:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive every DUT input in one go.
   task automatic applyStimulus(input logic fv, input logic [2:0] ftq, input logic [19:0] fa,
                                input logic [127:0] fcl, input logic cv, input logic [1:0] cop,
                                input logic [2:0] ctq, input logic [19:0] ca,
                                input logic [31:0] cd, input logic stall, input logic r);
      fill_lu_valid   = fv;
      fill_lu_tq_id   = ftq;
      fill_lu_address = fa;
      fill_lu_cl_data = fcl;
      core_lu_valid   = cv;
      core_lu_op      = cop;
      core_lu_tq_id   = ctq;
      core_lu_address = ca;
      core_lu_data    = cd;
      pipe_stall      = stall;
      rst             = r;
   endtask

   // Check the readies mid-cycle. Queue the expected output if a grant is
   // due, then advance to just after the next rising edge.
   task automatic run_cycle(input string name, input logic exp_cr, input logic exp_fr,
                            input logic push_en, input logic [185:0] exp);
      @(negedge clk);
      checkOutput({name, "_core_ready"}, 186'(core_lu_ready), 186'(exp_cr));
      checkOutput({name, "_fill_ready"}, 186'(fill_lu_ready), 186'(exp_fr));
      if (push_en) exp_q.push_back(exp);
      @(posedge clk);
      #1;
   endtask

   // Monitor. The output register loads on an edge with neither stall nor
   // reset. Each such load showing valid must match the oldest expected
   // entry. An expected entry with no valid output is reported missing.
   always @(posedge clk) begin
      mon_loaded = !pipe_stall && !rst;
      #2;
      if (mon_loaded) begin
         if (lu_req[185]) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_lu_req: got %h expected no request", lu_req);
            end else begin
               checkOutput("lu_req", lu_req, exp_q.pop_front());
            end
         end else if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL missing_lu_req: got %h expected %h", lu_req, exp_q.pop_front());
         end
      end
   end

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus sequence.
   initial begin
      logic [185:0] last_fill;
      int           cidx;

      // Reset with both requesters asserted. Nothing may be accepted.
      applyStimulus(1'b1, 3'd1, 20'h11111, cl_of(99), 1'b1, OP_RD, 3'd3, 20'h22222, 32'd0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      run_cycle("reset0", 1'b0, 1'b0, 1'b0, '0);
      run_cycle("reset1", 1'b0, 1'b0, 1'b0, '0);
      checkOutput("reset_lu_req", lu_req, '0);
      checkOutput("reset_arb_err", 186'(arb_err), '0);

      // First cycle out of reset: a single core read, accepted immediately.
      applyStimulus(1'b0, 3'd0, 20'h0, '0, 1'b1, OP_RD, 3'd2, 20'h01234, 32'd0, 1'b0, 1'b0);
      run_cycle("core_rd", 1'b1, 1'b0, 1'b1, mk_core(OP_RD, 3'd2, 20'h01234, 32'd0));

      // Core write carrying a data word.
      applyStimulus(1'b0, 3'd0, 20'h0, '0, 1'b1, OP_WR, 3'd6, 20'hABCDE, 32'hDEADBEEF, 1'b0, 1'b0);
      run_cycle("core_wr", 1'b1, 1'b0, 1'b1, mk_core(OP_WR, 3'd6, 20'hABCDE, 32'hDEADBEEF));

      // Simultaneous fill and core requests to the same address. The fill wins.
      applyStimulus(1'b1, 3'd5, 20'h01234, cl_of(1), 1'b1, OP_RD, 3'd1, 20'h01234, 32'h12345678, 1'b0, 1'b0);
      run_cycle("simul", 1'b0, 1'b1, 1'b1, mk_fill(3'd5, 20'h01234, cl_of(1)));

      // Idle cycle. The bus clears and the streak resets because the core dropped.
      applyStimulus(1'b0, 3'd0, 20'h0, '0, 1'b0, OP_NO, 3'd0, 20'h0, 32'd0, 1'b0, 1'b0);
      run_cycle("idle0", 1'b0, 1'b0, 1'b0, '0);
      checkOutput("idle_lu_req", lu_req, '0);

      // Starvation bound. The grant order must be F,F,F,F,C repeating.
      cidx = 0;
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b1, 3'(k), 20'h30000 + 20'(k), cl_of(k), 1'b1, OP_WR, 3'd4,
                       20'h40000 + 20'(cidx), 32'hC0DE0000 + 32'(cidx), 1'b0, 1'b0);
         if ((k % 5) == 4) begin
            run_cycle("starve_core", 1'b1, 1'b0, 1'b1,
                      mk_core(OP_WR, 3'd4, 20'h40000 + 20'(cidx), 32'hC0DE0000 + 32'(cidx)));
            cidx++;
         end else begin
            run_cycle("starve_fill", 1'b0, 1'b1, 1'b1,
                      mk_fill(3'(k), 20'h30000 + 20'(k), cl_of(k)));
         end
      end
      applyStimulus(1'b0, 3'd0, 20'h0, '0, 1'b0, OP_NO, 3'd0, 20'h0, 32'd0, 1'b0, 1'b0);
      run_cycle("idle1", 1'b0, 1'b0, 1'b0, '0);

      // Stall hold. Build the streak to 2, then stall for 3 cycles.
      for (int k = 0; k < 2; k++) begin
         applyStimulus(1'b1, 3'(k + 1), 20'h50000 + 20'(k), cl_of(20 + k), 1'b1, OP_RD, 3'd7,
                       20'h60000, 32'd0, 1'b0, 1'b0);
         run_cycle("prestall_fill", 1'b0, 1'b1, 1'b1,
                   mk_fill(3'(k + 1), 20'h50000 + 20'(k), cl_of(20 + k)));
      end
      last_fill = mk_fill(3'd2, 20'h50001, cl_of(21));
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 3'd3, 20'h50002, cl_of(22), 1'b1, OP_RD, 3'd7, 20'h60000, 32'd0, 1'b1, 1'b0);
         run_cycle("stall", 1'b0, 1'b0, 1'b0, '0);
         checkOutput("stall_hold", lu_req, last_fill);
      end
      // Arbitration resumes in the release cycle. With the streak still at 2,
      // the order is F,F,C.
      applyStimulus(1'b1, 3'd3, 20'h50002, cl_of(22), 1'b1, OP_RD, 3'd7, 20'h60000, 32'd0, 1'b0, 1'b0);
      run_cycle("resume_fill", 1'b0, 1'b1, 1'b1, mk_fill(3'd3, 20'h50002, cl_of(22)));
      applyStimulus(1'b1, 3'd4, 20'h50003, cl_of(23), 1'b1, OP_RD, 3'd7, 20'h60000, 32'd0, 1'b0, 1'b0);
      run_cycle("resume_fill", 1'b0, 1'b1, 1'b1, mk_fill(3'd4, 20'h50003, cl_of(23)));
      run_cycle("resume_core", 1'b1, 1'b0, 1'b1, mk_core(OP_RD, 3'd7, 20'h60000, 32'd0));
      applyStimulus(1'b0, 3'd0, 20'h0, '0, 1'b0, OP_NO, 3'd0, 20'h0, 32'd0, 1'b0, 1'b0);
      run_cycle("idle2", 1'b0, 1'b0, 1'b0, '0);

      // Illegal core opcode. It is accepted and dropped, and the error goes sticky.
      applyStimulus(1'b0, 3'd0, 20'h0, '0, 1'b1, OP_FILL, 3'd3, 20'h55555, 32'h00000BAD, 1'b0, 1'b0);
      run_cycle("illegal", 1'b1, 1'b0, 1'b0, '0);
      checkOutput("illegal_lu_req", lu_req, '0);
      checkOutput("illegal_arb_err", 186'(arb_err), 186'(1'b1));
      applyStimulus(1'b0, 3'd0, 20'h0, '0, 1'b1, OP_RD, 3'd0, 20'h00042, 32'd0, 1'b0, 1'b0);
      run_cycle("post_illegal_rd", 1'b1, 1'b0, 1'b1, mk_core(OP_RD, 3'd0, 20'h00042, 32'd0));
      applyStimulus(1'b0, 3'd0, 20'h0, '0, 1'b0, OP_NO, 3'd0, 20'h0, 32'd0, 1'b0, 1'b0);
      run_cycle("idle3", 1'b0, 1'b0, 1'b0, '0);
      checkOutput("arb_err_sticky", 186'(arb_err), 186'(1'b1));

      // Reset mid-operation. Three fills push the streak to 3.
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 3'(k), 20'h70000 + 20'(k), cl_of(40 + k), 1'b1, OP_WR, 3'd6,
                       20'h71111, 32'h0000ABCD, 1'b0, 1'b0);
         run_cycle("prerst_fill", 1'b0, 1'b1, 1'b1,
                   mk_fill(3'(k), 20'h70000 + 20'(k), cl_of(40 + k)));
      end
      // Now assert reset together with a stall while lu_req is valid.
      applyStimulus(1'b1, 3'd3, 20'h70003, cl_of(43), 1'b1, OP_WR, 3'd6, 20'h71111, 32'h0000ABCD, 1'b1, 1'b1);
      run_cycle("rst_mid", 1'b0, 1'b0, 1'b0, '0);
      checkOutput("rst_mid_lu_req", lu_req, '0);
      checkOutput("rst_mid_arb_err", 186'(arb_err), '0);
      // The streak restarts at 0. The order must be F,F,F,F,C again.
      for (int k = 0; k < 5; k++) begin
         if (k < 4) begin
            applyStimulus(1'b1, 3'(k + 3), 20'h70003 + 20'(k), cl_of(43 + k), 1'b1, OP_WR, 3'd6,
                          20'h71111, 32'h0000ABCD, 1'b0, 1'b0);
            run_cycle("postrst_fill", 1'b0, 1'b1, 1'b1,
                      mk_fill(3'(k + 3), 20'h70003 + 20'(k), cl_of(43 + k)));
         end else begin
            run_cycle("postrst_core", 1'b1, 1'b0, 1'b1,
                      mk_core(OP_WR, 3'd6, 20'h71111, 32'h0000ABCD));
         end
      end
      applyStimulus(1'b0, 3'd0, 20'h0, '0, 1'b0, OP_NO, 3'd0, 20'h0, 32'd0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #5;
      checkOutput("scoreboard_drained", 186'(exp_q.size()), '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
